// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller: FSM state encoding and the
// cause-code width helper used to size the channel index.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQ     = 2'b01,
      SERVICE = 2'b10
   } irq_state_e;

   // A single channel still needs a one-bit cause field.
   function automatic int cause_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: returns the index of the lowest set bit
// and a valid flag. Also reusable by the exception-cause logic.
module irq_prio_enc #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid
);

   // Scan from the top so the lowest set index is the last assignment.
   always_comb begin
      idx   = '0;
      valid = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches level/edge peripheral lines, masks them with
// an enable register and holds a frozen request + cause until the pipeline takes it.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int               N_IRQ     = 4,
   parameter logic [N_IRQ-1:0] EDGE_MASK = '0,
   parameter int               CAUSE_W   = cause_width(N_IRQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_IRQ-1:0]   irq_in,
   input  logic               pc_kernel,
   input  logic               en_we,
   input  logic [N_IRQ-1:0]   en_wdata,
   input  logic               clr_we,
   input  logic [N_IRQ-1:0]   clr_mask,
   input  logic               irq_take,
   output logic               irq_req,
   output logic [CAUSE_W-1:0] irq_cause,
   output logic [N_IRQ-1:0]   pending,
   output logic [N_IRQ-1:0]   enable,
   output logic [N_IRQ-1:0]   lost
);

   irq_state_e         state_q, state_d;
   logic [N_IRQ-1:0]   irq_prev_q, irq_prev_d;
   logic [N_IRQ-1:0]   pending_q, pending_d;
   logic [N_IRQ-1:0]   enable_q, enable_d;
   logic [N_IRQ-1:0]   lost_q, lost_d;
   logic               kernel_q, kernel_d;
   logic               req_q, req_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;

   logic [N_IRQ-1:0]   rise;
   logic [N_IRQ-1:0]   take_clr;
   logic [N_IRQ-1:0]   sw_clr;
   logic [N_IRQ-1:0]   candidate;
   logic [CAUSE_W-1:0] cand_idx;
   logic               cand_valid;
   logic               take_fire;

   assign candidate = pending_q & enable_q;

   irq_prio_enc #(
      .N (N_IRQ),
      .W (CAUSE_W)
   ) u_prio (
      .req   (candidate),
      .idx   (cand_idx),
      .valid (cand_valid)
   );

   // A new edge always overrides a same-cycle take or software clear.
   always_comb begin
      rise       = irq_in & ~irq_prev_q & EDGE_MASK;
      take_fire  = (state_q == REQ) && irq_take;
      take_clr   = take_fire ? (N_IRQ'(1) << cause_q) : '0;
      sw_clr     = clr_we ? clr_mask : '0;
      pending_d  = (EDGE_MASK & (rise | (pending_q & ~take_clr & ~sw_clr)))
                 | (~EDGE_MASK & irq_in);
      lost_d     = (lost_q & ~sw_clr) | (rise & pending_q & ~take_clr & ~sw_clr);
      enable_d   = en_we ? en_wdata : enable_q;
      irq_prev_d = irq_in;
      kernel_d   = pc_kernel;
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cause_d = cause_q;
      case (state_q)
         IDLE: begin
            if (cand_valid && !kernel_q) begin
               state_d = REQ;
               req_d   = 1'b1;
               cause_d = cand_idx;
            end
         end
         REQ: begin
            if (irq_take) begin
               state_d = SERVICE;
               req_d   = 1'b0;
            end
         end
         SERVICE: begin
            if (!kernel_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         irq_prev_q <= '0;
         pending_q  <= '0;
         enable_q   <= '0;
         lost_q     <= '0;
         kernel_q   <= 1'b0;
         req_q      <= 1'b0;
         cause_q    <= '0;
      end else begin
         state_q    <= state_d;
         irq_prev_q <= irq_prev_d;
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         lost_q     <= lost_d;
         kernel_q   <= kernel_d;
         req_q      <= req_d;
         cause_q    <= cause_d;
      end
   end

   assign irq_req   = req_q;
   assign irq_cause = cause_q;
   assign pending   = pending_q;
   assign enable    = enable_q;
   assign lost      = lost_q;

endmodule
